ram_arbiter: RTL and testbench

Two-master Wishbone arbiter in front of the SDRAM controller's single Wishbone slave port. It shares the port between the HPS ioctl loader and the Archimedes core memory bus. Loader writes are captured into a holding register, and the loader is throttled with ioctl_wait. The core keeps ownership for the full length of a registered-feedback burst. This block replaces the purely combinational loader/core mux.

---
 rtl/ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master Wishbone arbiter sharing the SDRAM slave port between the ioctl loader and the core bus.
// Loader writes go through a one-entry holding register; the core keeps the grant for a whole burst.
module ram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ram_ready,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [31:0]       ioctl_dout,
    input  logic [3:0]        ioctl_sel,
    output logic              ioctl_wait,
    input  logic              core_stb,
    input  logic              core_cyc,
    input  logic              core_we,
    input  logic [3:0]        core_sel,
    input  logic [2:0]        core_cti,
    input  logic [ADDR_W-3:0] core_adr,
    input  logic [31:0]       core_dat_o,
    output logic              core_ack,
    output logic              core_err,
    output logic              loader_err,
    output logic              ram_stb,
    output logic              ram_cyc,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [2:0]        ram_cti,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [31:0]       ram_dat_i,
    input  logic              ram_ack,
    output logic              core_busy
);

    localparam int WD_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, CORE, LOAD} state_t;

    state_t            state;
    logic              pend;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_dat;
    logic [3:0]        h_sel;
    logic [WD_W-1:0]   wd_cnt;
    logic              dl_q;
    logic              abort;

    assign abort      = (TIMEOUT != 0) && (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT));
    assign ioctl_wait = pend;
    assign core_busy  = (state == LOAD) | pend;

    // Slave side is a combinational view of the registered grant; the abort cycle forces it idle.
    always_comb begin
        ram_stb   = 1'b0;
        ram_cyc   = 1'b0;
        ram_we    = 1'b0;
        ram_sel   = '0;
        ram_cti   = '0;
        ram_adr   = '0;
        ram_dat_i = '0;
        core_ack  = 1'b0;
        core_err  = 1'b0;
        unique case (state)
            CORE: begin
                if (abort) begin
                    core_err = ~reset;
                end else begin
                    ram_stb   = core_stb;
                    ram_cyc   = core_cyc;
                    ram_we    = core_we;
                    ram_sel   = core_sel;
                    ram_cti   = core_cti;
                    ram_adr   = {core_adr, 2'b00};
                    ram_dat_i = core_dat_o;
                    core_ack  = ram_ack & ~reset;
                end
            end
            LOAD: begin
                if (!abort) begin
                    ram_stb   = 1'b1;
                    ram_cyc   = 1'b1;
                    ram_we    = 1'b1;
                    ram_sel   = h_sel;
                    ram_adr   = h_addr & ~ADDR_W'(3);
                    ram_dat_i = h_dat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            pend       <= 1'b0;
            h_addr     <= '0;
            h_dat      <= '0;
            h_sel      <= '0;
            wd_cnt     <= '0;
            dl_q       <= 1'b0;
            loader_err <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (ioctl_download && !dl_q)
                loader_err <= 1'b0;

            // A write strobe while the register is still full is dropped.
            if (ioctl_wr && !pend) begin
                h_addr <= ioctl_addr;
                h_dat  <= ioctl_dout;
                h_sel  <= ioctl_sel;
                pend   <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (pend && ram_ready)
                        state <= LOAD;
                    else if (core_cyc && core_stb && ram_ready)
                        state <= CORE;
                end
                CORE: begin
                    if (abort) begin
                        state  <= IDLE;
                        wd_cnt <= '0;
                    end else if (ram_ack) begin
                        wd_cnt <= '0;
                        if (core_cti != 3'b010 || !core_cyc)
                            state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (!core_cyc)
                            state <= IDLE;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        pend       <= 1'b0;
                        loader_err <= 1'b1;
                        wd_cnt     <= '0;
                    end else if (ram_ack) begin
                        state  <= IDLE;
                        pend   <= 1'b0;
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: loader path, core classic/burst, priority, watchdog, ram_ready and reset.
module tb_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ram_ready;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [23:0] ioctl_addr;
    logic [31:0] ioctl_dout;
    logic [3:0]  ioctl_sel;
    logic        ioctl_wait;
    logic        core_stb;
    logic        core_cyc;
    logic        core_we;
    logic [3:0]  core_sel;
    logic [2:0]  core_cti;
    logic [21:0] core_adr;
    logic [31:0] core_dat_o;
    logic        core_ack;
    logic        core_err;
    logic        loader_err;
    logic        ram_stb;
    logic        ram_cyc;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [2:0]  ram_cti;
    logic [23:0] ram_adr;
    logic [31:0] ram_dat_i;
    logic        ram_ack;
    logic        core_busy;

    int tests = 0;
    int fails = 0;
    int cnt;

    ram_arbiter #(.ADDR_W(24), .TIMEOUT(8)) dut (
        .clk_sys(clk_sys), .reset(reset), .ram_ready(ram_ready),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_sel(ioctl_sel), .ioctl_wait(ioctl_wait),
        .core_stb(core_stb), .core_cyc(core_cyc), .core_we(core_we), .core_sel(core_sel),
        .core_cti(core_cti), .core_adr(core_adr), .core_dat_o(core_dat_o),
        .core_ack(core_ack), .core_err(core_err), .loader_err(loader_err),
        .ram_stb(ram_stb), .ram_cyc(ram_cyc), .ram_we(ram_we), .ram_sel(ram_sel),
        .ram_cti(ram_cti), .ram_adr(ram_adr), .ram_dat_i(ram_dat_i), .ram_ack(ram_ack),
        .core_busy(core_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic core_req(input logic on, input logic [21:0] adr, input logic [2:0] cti);
        core_cyc = on;
        core_stb = on;
        core_we  = 1'b0;
        core_sel = 4'hF;
        core_adr = adr;
        core_cti = cti;
    endtask

    task automatic loader_wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_sel  = s;
    endtask

    initial begin
        reset = 1'b1; ram_ready = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_sel = '0; ram_ack = 1'b0;
        core_req(1'b0, '0, 3'b000); core_dat_o = 32'hCAFE0001;
        tick; tick;
        check("rst_stb", ram_stb, 0);
        check("rst_cyc", ram_cyc, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_busy", core_busy, 0);
        check("rst_lerr", loader_err, 0);
        check("rst_adr", ram_adr, 0);
        reset = 1'b0; ram_ready = 1'b1; ioctl_download = 1'b1;
        tick;

        // Loader single write, ack in the third strobe cycle
        cnt = 0;
        loader_wr(24'h000104, 32'hDEADBEEF, 4'hF);
        tick; ioctl_wr = 1'b0; #1;
        check("ld_arb_stb", ram_stb, 0);
        cnt += int'(ioctl_wait);
        tick;
        check("ld_stb", ram_stb, 1);
        check("ld_we", ram_we, 1);
        check("ld_adr", ram_adr, 24'h000104);
        check("ld_dat", ram_dat_i, 32'hDEADBEEF);
        check("ld_sel", ram_sel, 4'hF);
        check("ld_cti", ram_cti, 0);
        cnt += int'(ioctl_wait);
        tick; cnt += int'(ioctl_wait);
        tick; ram_ack = 1'b1; #1;
        check("ld_core_ack", core_ack, 0);
        cnt += int'(ioctl_wait);
        tick; ram_ack = 1'b0; #1;
        cnt += int'(ioctl_wait);
        check("ld_wait_cycles", cnt, 4);
        check("ld_done_stb", ram_stb, 0);
        check("ld_done_busy", core_busy, 0);

        // Core classic read
        core_req(1'b1, 22'h000040, 3'b000); #1;
        check("cr_arb_stb", ram_stb, 0);
        tick;
        check("cr_stb", ram_stb, 1);
        check("cr_adr", ram_adr, 24'h000100);
        check("cr_we", ram_we, 0);
        check("cr_noack", core_ack, 0);
        ram_ack = 1'b1; #1;
        check("cr_ack", core_ack, 1);
        tick; ram_ack = 1'b0; #1;
        check("cr_idle_stb", ram_stb, 0);
        core_req(1'b0, '0, 3'b000);
        tick;

        // Core 4-beat burst with a loader write arriving at beat 2
        cnt = 0;
        core_req(1'b1, 22'h000080, 3'b010);
        tick;
        for (int b = 0; b < 4; b++) begin
            core_adr = 22'h000080 + 22'(b);
            core_cti = (b == 3) ? 3'b111 : 3'b010;
            ram_ack  = 1'b1;
            if (b == 1) loader_wr(24'h000208, 32'h12345678, 4'h3);
            #1;
            check("bu_we", ram_we, 0);
            if (b >= 2) check("bu_wait", ioctl_wait, 1);
            cnt += int'(core_ack);
            tick;
            ioctl_wr = 1'b0;
        end
        ram_ack = 1'b0; core_req(1'b0, '0, 3'b000); #1;
        check("bu_acks", cnt, 4);
        check("bu_idle_stb", ram_stb, 0);
        check("bu_idle_wait", ioctl_wait, 1);
        tick;
        check("bu_ld_we", ram_we, 1);
        check("bu_ld_adr", ram_adr, 24'h000208);
        check("bu_ld_sel", ram_sel, 4'h3);
        ram_ack = 1'b1; #1;
        check("bu_ld_coreack", core_ack, 0);
        tick; ram_ack = 1'b0; #1;
        check("bu_ld_wait", ioctl_wait, 0);

        // Pending loader and core request together in IDLE: loader first
        loader_wr(24'h000300, 32'hA5A5A5A5, 4'hF);
        tick; ioctl_wr = 1'b0;
        core_req(1'b1, 22'h000010, 3'b000); #1;
        check("pr_arb_stb", ram_stb, 0);
        tick;
        check("pr_ld_we", ram_we, 1);
        check("pr_ld_adr", ram_adr, 24'h000300);
        ram_ack = 1'b1; #1;
        check("pr_ld_coreack", core_ack, 0);
        tick; ram_ack = 1'b0; #1;
        check("pr_idle_stb", ram_stb, 0);
        tick;
        check("pr_core_stb", ram_stb, 1);
        check("pr_core_we", ram_we, 0);
        check("pr_core_adr", ram_adr, 24'h000040);
        ram_ack = 1'b1; #1;
        check("pr_core_ack", core_ack, 1);
        tick; ram_ack = 1'b0; core_req(1'b0, '0, 3'b000);
        tick;

        // Watchdog on a core read, loader write pending behind it
        core_req(1'b1, 22'h000020, 3'b000);
        tick;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) loader_wr(24'h000400, 32'h0BADF00D, 4'hF);
            #1;
            cnt += int'(ram_stb & ~core_err);
            tick;
            ioctl_wr = 1'b0;
        end
        check("wd_stb_cycles", cnt, 8);
        check("wd_err", core_err, 1);
        check("wd_stb_drop", ram_stb, 0);
        check("wd_cyc_drop", ram_cyc, 0);
        core_req(1'b0, '0, 3'b000);
        tick;
        check("wd_err_pulse", core_err, 0);
        check("wd_wait", ioctl_wait, 1);
        tick;
        check("wd_ld_stb", ram_stb, 1);
        check("wd_ld_adr", ram_adr, 24'h000400);
        ram_ack = 1'b1;
        tick; ram_ack = 1'b0; #1;
        check("wd_ld_done", ioctl_wait, 0);

        // Watchdog on a loader write, then clear loader_err on download rise
        loader_wr(24'h000500, 32'h11111111, 4'hF);
        tick; ioctl_wr = 1'b0;
        tick;
        for (int k = 0; k < 8; k++) tick;
        check("lwd_stb_drop", ram_stb, 0);
        check("lwd_coreerr", core_err, 0);
        tick;
        check("lwd_lerr", loader_err, 1);
        check("lwd_wait", ioctl_wait, 0);
        ioctl_download = 1'b0;
        tick;
        check("lwd_lerr_hold", loader_err, 1);
        ioctl_download = 1'b1;
        tick;
        check("lwd_lerr_clr", loader_err, 0);

        // ram_ready low blocks grants; dropped second write; reset mid-LOAD
        ram_ready = 1'b0;
        loader_wr(24'h000600, 32'h22222222, 4'hF);
        core_req(1'b1, 22'h000030, 3'b000);
        tick;
        loader_wr(24'h000700, 32'h33333333, 4'h1);
        tick; ioctl_wr = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cnt += int'(ram_stb);
            tick;
        end
        check("rdy_no_stb", cnt, 0);
        ram_ready = 1'b1; #1;
        check("rdy_arb_stb", ram_stb, 0);
        tick;
        check("rdy_ld_stb", ram_stb, 1);
        check("rdy_ld_adr", ram_adr, 24'h000600);
        check("rdy_ld_dat", ram_dat_i, 32'h22222222);
        reset = 1'b1;
        tick; reset = 1'b0; core_req(1'b0, '0, 3'b000); #1;
        check("mrst_wait", ioctl_wait, 0);
        check("mrst_stb", ram_stb, 0);
        check("mrst_busy", core_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
